pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard, stall, flush and forwarding control for a five-stage in-order pipeline.
//   A scoreboard tracks the destination register of each instruction downstream of
//   decode (entry0 = EX, entry1 = MEM, entry2 = WB for the default depth). Decode
//   sources are compared against it to pick forwarding sources or to stall. A small
//   FSM sequences load-use stalls, data-memory wait freezes and the memory timeout fault.
//
// Ports
//   clk, reset                    clock, synchronous active-low reset
//   id_valid                      decode holds a real instruction
//   id_rs1/id_rs2, id_use_rs1/2   decode source registers and whether each is read
//   id_rd, id_we, id_is_load      decode destination, write enable, load flag
//   branch_taken                  taken branch resolved in EX/MEM
//   mem_req, mem_ready            MEM stage data-memory handshake
//   stall_if, stall_id            hold PC / IF-ID register
//   bubble_ex                     insert NOP into ID-EX
//   flush_ifid/idex/exmem         squash pipeline registers
//   freeze                        hold every pipeline register
//   fwd_a_sel, fwd_b_sel          0 = register file, k = scoreboard entry k-1
//   mem_timeout                   sticky memory-wait fault (registered)
//
// Build option
//   PIPELINE_CTRL_FORWARDING_EN   defined: forward from the scoreboard, stall only on
//                                 load-use. Undefined: no forwarding, stall while any
//                                 scoreboard entry matches a decode source.
module pipeline_ctrl #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned TRACK_DEPTH = 3,
  parameter int unsigned MEM_LAT_MAX = 4,
  localparam int unsigned REG_W      = $clog2(NUM_REGS),
  localparam int unsigned SEL_W      = $clog2(TRACK_DEPTH + 1),
  localparam int unsigned CNT_W      = $clog2(MEM_LAT_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             freeze,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             mem_timeout
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    StRun,
    StLoadStall,
    StMemWait,
    StFault
  } state_e;

  sb_entry_t        sb_q [TRACK_DEPTH];
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [TRACK_DEPTH-1:0] match_a, match_b;
  logic                   mem_wait, frz, flush, hazard, stall_haz, ls_enter;
  logic [SEL_W-1:0]       sel_a, sel_b;

  // Per-entry source match: a live writer of a non-zero register that decode reads.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      match_a[i] = id_valid & id_use_rs1 & sb_q[i].valid & sb_q[i].we &
                   (sb_q[i].rd != '0) & (sb_q[i].rd == id_rs1);
      match_b[i] = id_valid & id_use_rs2 & sb_q[i].valid & sb_q[i].we &
                   (sb_q[i].rd != '0) & (sb_q[i].rd == id_rs2);
    end
  end

  assign mem_wait = mem_req & ~mem_ready;
  assign frz      = (state_q == StFault) | mem_wait;
  assign flush    = branch_taken & ~frz;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  logic load_use;

  // The load's data is not available until after MEM, so a load sitting in EX cannot
  // forward; the single LOAD_STALL cycle lets it move to entry1 first.
  assign load_use = (match_a[0] | match_b[0]) & sb_q[0].is_load & (state_q != StLoadStall);
  assign hazard   = load_use;
  assign ls_enter = load_use & ~frz & ~flush;

  // Walk oldest to youngest so the youngest eligible match wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = TRACK_DEPTH - 1; i >= 0; i--) begin
      if (!(i == 0 && sb_q[0].is_load)) begin
        if (match_a[i]) sel_a = SEL_W'(i + 1);
        if (match_b[i]) sel_b = SEL_W'(i + 1);
      end
    end
  end
`else
  logic [TRACK_DEPTH-1:0] unused_is_load;

  assign hazard   = |(match_a | match_b);
  assign ls_enter = 1'b0;
  assign sel_a    = '0;
  assign sel_b    = '0;

  always_comb begin
    unused_is_load = '0;
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      unused_is_load[i] = sb_q[i].is_load;
    end
  end
`endif

  // Freeze overrides everything; a taken branch squashes the stalled instruction anyway.
  assign stall_haz = hazard & ~frz & ~flush;

  // Scoreboard shift register, held while frozen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else if (!frz) begin
      for (int i = TRACK_DEPTH - 1; i > 0; i--) begin
        sb_q[i] <= sb_q[i-1];
      end
      sb_q[0].valid   <= id_valid & ~stall_haz & ~flush;
      sb_q[0].rd      <= id_rd;
      sb_q[0].we      <= id_we;
      sb_q[0].is_load <= id_is_load;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StRun, StLoadStall: begin
        if (mem_wait) begin
          state_d = StMemWait;
          cnt_d   = '0;
        end else if (ls_enter) begin
          state_d = StLoadStall;
        end else begin
          state_d = StRun;
        end
      end
      StMemWait: begin
        if (mem_wait) begin
          if (cnt_q != CNT_W'(MEM_LAT_MAX)) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(MEM_LAT_MAX)) begin
            state_d   = StFault;
            timeout_d = 1'b1;
          end
        end else begin
          state_d = StRun;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Every output is forced low while reset is held, whatever the FSM state.
  assign stall_if    = reset & (frz | stall_haz);
  assign stall_id    = reset & (frz | stall_haz);
  assign bubble_ex   = reset & stall_haz;
  assign flush_ifid  = reset & flush;
  assign flush_idex  = reset & flush;
  assign flush_exmem = reset & flush;
  assign freeze      = reset & frz;
  assign fwd_a_sel   = reset ? sel_a : '0;
  assign fwd_b_sel   = reset ? sel_b : '0;
  assign mem_timeout = reset & timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_we, id_is_load;
  logic             branch_taken, mem_req, mem_ready;
  logic             stall_if, stall_id, bubble_ex;
  logic             flush_ifid, flush_idex, flush_exmem, freeze;
  logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
  logic             mem_timeout;

  int n_tests;
  int n_fail;

  pipeline_ctrl #(
    .NUM_REGS   (32),
    .TRACK_DEPTH(3),
    .MEM_LAT_MAX(4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .flush_exmem (flush_exmem),
    .freeze      (freeze),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .mem_timeout (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [REG_W-1:0] rs1, input logic u1,
                     input logic [REG_W-1:0] rs2, input logic u2,
                     input logic [REG_W-1:0] rd, input logic we, input logic ld);
    id_valid   = v;
    id_rs1     = rs1;
    id_use_rs1 = u1;
    id_rs2     = rs2;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_we      = we;
    id_is_load = ld;
  endtask

  task automatic drain();
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with hostile inputs: every output must read 0.
    reset        = 1'b0;
    branch_taken = 1'b1;
    mem_req      = 1'b1;
    mem_ready    = 1'b0;
    dec(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
    #2;
    check("rst_stall_if", 32'(stall_if), 32'd0);
    check("rst_bubble", 32'(bubble_ex), 32'd0);
    check("rst_flush", 32'(flush_ifid | flush_idex | flush_exmem), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    drain();

    // add x5 in EX, decode reads x5 through rs1.
    dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    #2;
    check("add_issue_stall", 32'(stall_if), 32'd0);
    tick();
    dec(1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
    #2;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    check("raw_fwd_a", 32'(fwd_a_sel), 32'd1);
    check("raw_no_stall", 32'(stall_if | stall_id | bubble_ex), 32'd0);
    tick();
`else
    for (int c = 0; c < 3; c++) begin
      check("raw_nofwd_stall", 32'({stall_if, stall_id, bubble_ex}), 32'd7);
      check("raw_nofwd_fwd", 32'(fwd_a_sel), 32'd0);
      tick();
      #2;
    end
    check("raw_nofwd_release", 32'(stall_if), 32'd0);
    tick();
`endif
    drain();

    // lw x7 in EX, decode reads x7 through rs2.
    dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    #2;
    check("lu_stall", 32'({stall_if, stall_id, bubble_ex}), 32'd7);
    check("lu_no_fwd_from_load", 32'(fwd_b_sel), 32'd0);
    tick();
    #2;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    check("lu_release", 32'({stall_if, stall_id, bubble_ex}), 32'd0);
    check("lu_fwd_b", 32'(fwd_b_sel), 32'd2);
`else
    check("lu_nofwd_stall2", 32'(bubble_ex), 32'd1);
    tick();
    #2;
    check("lu_nofwd_stall3", 32'(bubble_ex), 32'd1);
    tick();
    #2;
    check("lu_nofwd_release", 32'(bubble_ex), 32'd0);
`endif
    tick();
    drain();

    // Writer of x0 never creates a dependency.
    dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    #2;
    check("x0_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    check("x0_stall", 32'(stall_if | bubble_ex), 32'd0);
    tick();
    drain();

    // Taken branch in the load-use cycle: flush wins, no bubble, entry0 squashed.
    dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0);
    branch_taken = 1'b1;
    #2;
    check("br_flush", 32'({flush_ifid, flush_idex, flush_exmem}), 32'd7);
    check("br_no_bubble", 32'(bubble_ex), 32'd0);
    check("br_no_stall", 32'(stall_if), 32'd0);
    tick();
    branch_taken = 1'b0;
    dec(1'b1, 5'd9, 1'b1, 5'd2, 1'b0, 5'd10, 1'b1, 1'b0);
    #2;
    check("br_entry0_gone_fwd", 32'(fwd_a_sel), 32'd0);
    check("br_entry0_gone_stall", 32'(stall_if), 32'd0);
    tick();
    drain();

    // Memory wait with a pending branch: freeze first, flush once memory completes.
    dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd11, 1'b1, 1'b0);
    mem_req      = 1'b1;
    mem_ready    = 1'b0;
    branch_taken = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      check("mw_freeze", 32'({freeze, stall_if, stall_id}), 32'd7);
      check("mw_no_flush", 32'(flush_ifid | flush_idex | flush_exmem), 32'd0);
      check("mw_no_bubble", 32'(bubble_ex), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #2;
    check("mw_done_freeze", 32'(freeze), 32'd0);
    check("mw_done_flush", 32'({flush_ifid, flush_idex, flush_exmem}), 32'd7);
    tick();
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    dec(1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd12, 1'b1, 1'b0);
    #2;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    check("mw_sb_held", 32'(fwd_a_sel), 32'd2);
`else
    check("mw_sb_held", 32'(stall_if), 32'd1);
`endif
    tick();
    drain();

    // Memory never ready: four legal waits in MEM_WAIT, then a sticky timeout.
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("to_freeze", 32'(freeze), 32'd1);
      check("to_not_yet", 32'(mem_timeout), 32'd0);
      tick();
    end
    #2;
    check("to_raised", 32'(mem_timeout), 32'd1);
    mem_req   = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    #2;
    check("to_sticky", 32'(mem_timeout), 32'd1);
    check("to_fault_freeze", 32'(freeze), 32'd1);
    reset = 1'b0;
    #1;
    check("to_rst_forced", 32'({mem_timeout, freeze, stall_if}), 32'd0);
    tick();
    reset = 1'b1;
    #2;
    check("to_cleared", 32'(mem_timeout), 32'd0);
    check("to_unfrozen", 32'(freeze), 32'd0);
    tick();
    drain();

    // Reset in the middle of a load-use stall clears the scoreboard.
    dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    reset = 1'b0;
    #2;
    check("rst_mid_stall", 32'({stall_if, stall_id, bubble_ex}), 32'd0);
    tick();
    reset = 1'b1;
    #2;
    check("rst_sb_cleared", 32'({stall_if, bubble_ex, fwd_b_sel}), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
